// File: rtl/chiptune_pkg.sv
// Shared constants for the chiptune pulse synthesiser: duty patterns,
// length-counter lookup and register offsets within a channel.
package chiptune_pkg;

    // Duty patterns; bit 7 is sequencer step 0, bit 0 is step 7.
    localparam logic [7:0] DUTY_TABLE [4] = '{
        8'b0100_0000,
        8'b0110_0000,
        8'b0111_1000,
        8'b1001_1111
    };

    // NES APU length-counter load values, indexed by wr_data[7:3].
    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    // Register offsets within a channel.
    localparam logic [1:0] OFS_CTRL = 2'd0;
    localparam logic [1:0] OFS_LO   = 2'd1;
    localparam logic [1:0] OFS_HI   = 2'd2;
    localparam logic [1:0] OFS_EN   = 2'd3;

endpackage

// File: rtl/pulse_channel.sv
// One pulse voice: control registers, period timer, 8-step duty sequencer,
// volume envelope, length counter and the resulting 4-bit output level.
module pulse_channel
    import chiptune_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_240hz,
    input  logic       tick_120hz,
    input  logic       wr_en,
    input  logic [1:0] wr_ofs,
    input  logic [7:0] wr_data,
    output logic [3:0] level,
    output logic       active
);

    logic [1:0]  duty;
    logic        halt;
    logic        cnst;
    logic [3:0]  vol;
    logic [10:0] period;
    logic        enable;
    logic [10:0] timer;
    logic [2:0]  step;
    logic [7:0]  length;
    logic        env_start;
    logic [3:0]  env_div;
    logic [3:0]  decay;

    logic wr_ctrl;
    logic wr_lo;
    logic wr_hi;
    logic wr_enr;

    assign wr_ctrl = wr_en && (wr_ofs == OFS_CTRL);
    assign wr_lo   = wr_en && (wr_ofs == OFS_LO);
    assign wr_hi   = wr_en && (wr_ofs == OFS_HI);
    assign wr_enr  = wr_en && (wr_ofs == OFS_EN);
    assign active  = (length != 8'd0);

    // Software-visible control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            duty   <= 2'd0;
            halt   <= 1'b0;
            cnst   <= 1'b0;
            vol    <= 4'd0;
            period <= 11'd0;
            enable <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                duty <= wr_data[7:6];
                halt <= wr_data[5];
                cnst <= wr_data[4];
                vol  <= wr_data[3:0];
            end
            if (wr_lo)  period[7:0]  <= wr_data;
            if (wr_hi)  period[10:8] <= wr_data[2:0];
            if (wr_enr) enable       <= wr_data[0];
        end
    end

    // Period timer; each expiry advances the sequencer, a high write restarts it at step 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer <= 11'd0;
            step  <= 3'd0;
        end else begin
            if (timer == 11'd0) begin
                timer <= period;
                step  <= step + 3'd1;
            end else begin
                timer <= timer - 11'd1;
            end
            if (wr_hi) step <= 3'd0;
        end
    end

    // Envelope: a high write arms a restart that the next 240 Hz tick performs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            env_start <= 1'b0;
            env_div   <= 4'd0;
            decay     <= 4'd0;
        end else begin
            if (tick_240hz) begin
                if (env_start) begin
                    env_start <= 1'b0;
                    decay     <= 4'd15;
                    env_div   <= vol;
                end else if (env_div == 4'd0) begin
                    env_div <= vol;
                    if (decay != 4'd0) decay <= decay - 4'd1;
                    else if (halt)     decay <= 4'd15;
                end else begin
                    env_div <= env_div - 4'd1;
                end
            end
            if (wr_hi) env_start <= 1'b1;
        end
    end

    // Length counter: disable clears it, a load beats a same-cycle 120 Hz decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            length <= 8'd0;
        end else if (wr_enr && !wr_data[0]) begin
            length <= 8'd0;
        end else if (wr_hi && enable) begin
            length <= LENGTH_TABLE[wr_data[7:3]];
        end else if (tick_120hz && (length != 8'd0) && !halt) begin
            length <= length - 8'd1;
        end
    end

    // Output level; periods below 8 are ultrasonic and stay silent.
    always_comb begin
        level = 4'd0;
        if (DUTY_TABLE[duty][3'd7 - step] && (length != 8'd0) &&
            (period >= 11'd8) && enable) begin
            level = cnst ? vol : decay;
        end
    end

endmodule

// File: rtl/chiptune_poly.sv
// Polyphonic pulse synthesiser top: decodes register writes to NCH channels,
// sums their levels into a registered mix and renders the mix as PWM.
module chiptune_poly
    import chiptune_pkg::*;
#(
    parameter int NCH  = 2,
    parameter int MIXW = 4 + $clog2(NCH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick_240hz,
    input  logic                    tick_120hz,
    input  logic                    wr_en,
    input  logic [$clog2(NCH)+1:0]  wr_addr,
    input  logic [7:0]              wr_data,
    output logic                    pwm,
    output logic [MIXW-1:0]         mix,
    output logic [NCH-1:0]          active
);

    localparam int CHW = $clog2(NCH);

    logic [3:0]      level [NCH];
    logic [MIXW-1:0] mix_sum;
    logic [MIXW-1:0] pwm_cnt;
    logic [MIXW-1:0] pwm_duty;
    logic [MIXW-1:0] duty_next;

    // Channel numbers without an instance simply match no select line.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_wr;
        if (NCH > 1) begin : g_sel
            assign ch_wr = wr_en && (wr_addr[CHW+1:2] == CHW'(i));
        end else begin : g_one
            assign ch_wr = wr_en;
        end

        pulse_channel u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_240hz (tick_240hz),
            .tick_120hz (tick_120hz),
            .wr_en      (ch_wr),
            .wr_ofs     (wr_addr[1:0]),
            .wr_data    (wr_data),
            .level      (level[i]),
            .active     (active[i])
        );
    end

    // Unsigned sum of channel levels; MIXW leaves headroom for 15 * NCH.
    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NCH; i++) begin
            mix_sum = mix_sum + MIXW'(level[i]);
        end
    end

    // Duty is only replaced at counter zero so a PWM period never changes mid-way.
    always_comb begin
        duty_next = (pwm_cnt == '0) ? mix : pwm_duty;
    end

    // Mixer output register and PWM counter / comparator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mix      <= '0;
            pwm_cnt  <= '0;
            pwm_duty <= '0;
            pwm      <= 1'b0;
        end else begin
            mix      <= mix_sum;
            pwm_cnt  <= pwm_cnt + MIXW'(1);
            pwm_duty <= duty_next;
            pwm      <= (pwm_cnt < duty_next);
        end
    end

endmodule
